// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER data-port-2 arbiter.
// Covers FSM states, access-size encodings, port indices and small helpers.
package otter_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int PORT_CPU = 0;
    localparam int PORT_AUX = 1;

    function automatic logic [1:0] port_onehot(input logic port);
        return {port, ~port};
    endfunction

    // The unused 2'b11 encoding is forwarded to memory as a byte access
    function automatic logic [1:0] legal_size(input logic [1:0] sz);
        return (sz == SZ_WORD || sz == SZ_HALF) ? sz : SZ_BYTE;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way picker with a one-hot grant.
// last_gnt = 1 means port 1 was served last, so port 0 wins a tie.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (fixed_prio || last_gnt) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Serialises CPU and auxiliary-master accesses onto OTTER memory data port 2.
// IDLE grants and latches, ISSUE strobes memory, WAIT counts out the read latency.
module otter_mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter bit CPU_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic              sign0,
    input  logic              sign1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_rden2,
    output logic              mem_we2,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic [DATA_W-1:0] mem_din2,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    input  logic [DATA_W-1:0] mem_dout2
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t       state;
    logic             owner;
    logic             is_write;
    logic             last_gnt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       gnt;
    logic             sel;
    logic             sel_we;

    rr_arbiter_2 u_pick (
        .req        (req),
        .last_gnt   (last_gnt),
        .fixed_prio (CPU_PRIO),
        .gnt        (gnt)
    );

    assign sel    = gnt[1];
    assign sel_we = we[sel];

    // The mem_* registers double as the latched request: loaded at grant, held until done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= 1'(PORT_CPU);
            is_write  <= 1'b0;
            last_gnt  <= 1'(PORT_AUX);
            cnt       <= '0;
            ack       <= 2'b00;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_rden2 <= 1'b0;
            mem_we2   <= 1'b0;
            mem_addr2 <= '0;
            mem_din2  <= '0;
            mem_size  <= SZ_BYTE;
            mem_sign  <= 1'b0;
        end else begin
            ack       <= 2'b00;
            mem_rden2 <= 1'b0;
            mem_we2   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        owner     <= sel;
                        is_write  <= sel_we;
                        mem_addr2 <= sel ? addr1 : addr0;
                        mem_din2  <= sel ? wdata1 : wdata0;
                        mem_size  <= legal_size(sel ? size1 : size0);
                        mem_sign  <= sel ? sign1 : sign0;
                        mem_we2   <= sel_we;
                        mem_rden2 <= ~sel_we;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                        // A write completes in the strobe cycle itself
                        if (sel_we) begin
                            ack      <= port_onehot(sel);
                            last_gnt <= sel;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (is_write) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt   <= CNT_W'(MEM_LAT - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        rdata    <= mem_dout2;
                        ack      <= port_onehot(owner);
                        last_gnt <= owner;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: three instances (round-robin, CPU priority, 3-cycle memory)
// checked every cycle against a schedule model, plus directed literal checks.
`timescale 1ns/1ps
module tb_otter_mem_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_v [N];
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  size0, size1;
    logic        sign0, sign1;

    logic [1:0]  ack_v   [N];
    logic [31:0] rdata_v [N];
    logic        busy_v  [N];
    logic        rden_v  [N];
    logic        wen_v   [N];
    logic [31:0] maddr_v [N];
    logic [31:0] mdin_v  [N];
    logic [1:0]  msize_v [N];
    logic        msign_v [N];
    logic [31:0] dout_v  [N];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic bit prio_of(input int i);
        return (i == 1);
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h200) ? 32'h12345678 : {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            logic [31:0] pipe [3];

            otter_mem_arbiter #(
                .ADDR_W   (32),
                .DATA_W   (32),
                .MEM_LAT  ((gi == 2) ? 3 : 1),
                .CPU_PRIO (gi == 1)
            ) dut (
                .clk       (clk),
                .rst       (rst),
                .req       (req_v[gi]),
                .we        (we),
                .addr0     (addr0),
                .addr1     (addr1),
                .wdata0    (wdata0),
                .wdata1    (wdata1),
                .size0     (size0),
                .size1     (size1),
                .sign0     (sign0),
                .sign1     (sign1),
                .ack       (ack_v[gi]),
                .rdata     (rdata_v[gi]),
                .busy      (busy_v[gi]),
                .mem_rden2 (rden_v[gi]),
                .mem_we2   (wen_v[gi]),
                .mem_addr2 (maddr_v[gi]),
                .mem_din2  (mdin_v[gi]),
                .mem_size  (msize_v[gi]),
                .mem_sign  (msign_v[gi]),
                .mem_dout2 (dout_v[gi])
            );

            // Memory returns data exactly MEM_LAT cycles after the strobe, garbage otherwise
            always @(posedge clk) begin
                pipe[0] <= rden_v[gi] ? mem_val(maddr_v[gi]) : 32'hBAD0BAD0;
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end
            assign dout_v[gi] = pipe[(gi == 2) ? 2 : 0];
        end
    endgenerate

    // Model: each grant schedules strobe, busy window and ack by cycle number
    logic        m_act  [N];
    int          m_g    [N];
    int          m_ackc [N];
    int          m_free [N];
    logic        m_we   [N];
    logic        m_own  [N];
    logic        m_rr   [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_din  [N];
    logic [1:0]  m_size [N];
    logic        m_sign [N];
    logic [1:0]  e_ack;
    logic        e_busy, e_rd, e_wr, own;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_act[i]  = 1'b0;
                m_rr[i]   = 1'b0;
                m_free[i] = cyc + 1;
                chk($sformatf("u%0d_rst_ack", i), ack_v[i], 2'b00);
                chk($sformatf("u%0d_rst_busy", i), busy_v[i], 1'b0);
                chk($sformatf("u%0d_rst_rden", i), rden_v[i], 1'b0);
                chk($sformatf("u%0d_rst_we", i), wen_v[i], 1'b0);
                chk($sformatf("u%0d_rst_rdata", i), rdata_v[i], 32'h0);
                chk($sformatf("u%0d_rst_addr", i), maddr_v[i], 32'h0);
                chk($sformatf("u%0d_rst_din", i), mdin_v[i], 32'h0);
                chk($sformatf("u%0d_rst_size", i), msize_v[i], 2'b00);
                chk($sformatf("u%0d_rst_sign", i), msign_v[i], 1'b0);
            end else begin
                e_busy = m_act[i] && (cyc > m_g[i]) && (cyc < m_free[i]);
                e_wr   = m_act[i] && m_we[i] && (cyc == m_g[i] + 1);
                e_rd   = m_act[i] && !m_we[i] && (cyc == m_g[i] + 1);
                e_ack  = (m_act[i] && cyc == m_ackc[i]) ? (m_own[i] ? 2'b10 : 2'b01) : 2'b00;
                chk($sformatf("u%0d_ack", i), ack_v[i], e_ack);
                chk($sformatf("u%0d_busy", i), busy_v[i], e_busy);
                chk($sformatf("u%0d_rden", i), rden_v[i], e_rd);
                chk($sformatf("u%0d_we", i), wen_v[i], e_wr);
                if (e_busy) begin
                    chk($sformatf("u%0d_addr", i), maddr_v[i], m_addr[i]);
                    chk($sformatf("u%0d_size", i), msize_v[i], m_size[i]);
                    chk($sformatf("u%0d_sign", i), msign_v[i], m_sign[i]);
                end
                if (e_wr) chk($sformatf("u%0d_din", i), mdin_v[i], m_din[i]);
                if (e_ack != 2'b00) begin
                    if (!m_we[i]) chk($sformatf("u%0d_rdata", i), rdata_v[i], mem_val(m_addr[i]));
                    $display("txn u%0d port%0d %s addr=%h data=%h cycle=%0d", i, m_own[i],
                             m_we[i] ? "write" : "read", m_addr[i],
                             m_we[i] ? m_din[i] : rdata_v[i], cyc);
                end
                if (cyc >= m_free[i] && req_v[i] != 2'b00) begin
                    if (req_v[i] == 2'b11) own = prio_of(i) ? 1'b0 : m_rr[i];
                    else                   own = req_v[i][1];
                    m_act[i]  = 1'b1;
                    m_g[i]    = cyc;
                    m_own[i]  = own;
                    m_we[i]   = we[own];
                    m_addr[i] = own ? addr1 : addr0;
                    m_din[i]  = own ? wdata1 : wdata0;
                    m_size[i] = own ? size1 : size0;
                    m_sign[i] = own ? sign1 : sign0;
                    m_ackc[i] = m_we[i] ? cyc + 1 : cyc + 2 + lat_of(i);
                    m_free[i] = m_we[i] ? cyc + 2 : cyc + 2 + lat_of(i);
                    m_rr[i]   = ~own;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int i, input int budget, output logic [1:0] got, output int at);
        got = 2'b00;
        at  = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (ack_v[i] != 2'b00) begin
                got = ack_v[i];
                at  = cyc;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL u%0d_ack_timeout: got no ack within %0d cycles (cycle %0d)", i, budget, cyc);
    endtask

    task automatic contention(input int i, input logic [3:0] exp_order);
        logic [1:0] got;
        int         at;
        we = 2'b00;
        addr0 = 32'h400; size0 = 2'b00; sign0 = 1'b1;
        addr1 = 32'h500; size1 = 2'b01; sign1 = 1'b0;
        req_v[i] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(i, 10, got, at);
            if (k == 3) req_v[i] = 2'b00;
            chk($sformatf("u%0d_order%0d", i, k), got, exp_order[k] ? 2'b10 : 2'b01);
        end
        tick();
    endtask

    initial begin
        logic [1:0] got;
        int at, prev, busy_cnt, strobe_cnt, late_acks;

        rst = 1'b0;
        we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        size0 = 2'b00; size1 = 2'b00; sign0 = 1'b0; sign1 = 1'b0;
        for (int i = 0; i < N; i++) req_v[i] = 2'b00;
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // CPU write alone
        we = 2'b01; addr0 = 32'h100; wdata0 = 32'hDEADBEEF; size0 = 2'b10; sign0 = 1'b0;
        req_v[0] = 2'b01;
        tick();
        chk("wr_strobe", wen_v[0], 1'b1);
        chk("wr_addr", maddr_v[0], 32'h100);
        chk("wr_din", mdin_v[0], 32'hDEADBEEF);
        chk("wr_size", msize_v[0], 2'b10);
        chk("wr_ack", ack_v[0], 2'b01);
        chk("wr_no_rden", rden_v[0], 1'b0);
        req_v[0] = 2'b00;
        tick();
        chk("wr_ack_once", ack_v[0], 2'b00);
        chk("wr_strobe_once", wen_v[0], 1'b0);

        // AUX read, one-cycle memory
        we = 2'b00; addr1 = 32'h200; size1 = 2'b10; sign1 = 1'b0;
        req_v[0] = 2'b10;
        tick();
        chk("rd_strobe", rden_v[0], 1'b1);
        chk("rd_addr", maddr_v[0], 32'h200);
        tick();
        chk("rd_no_early_ack", ack_v[0], 2'b00);
        tick();
        chk("rd_ack", ack_v[0], 2'b10);
        chk("rd_data", rdata_v[0], 32'h12345678);
        req_v[0] = 2'b00;
        tick();

        contention(0, 4'b1010);
        contention(1, 4'b0000);

        // Port 0 read with req dropped mid-wait while port 1 is pending
        we = 2'b00; addr0 = 32'h600; size0 = 2'b10; sign0 = 1'b0;
        req_v[0] = 2'b01;
        tick();
        tick();
        req_v[0] = 2'b10; addr1 = 32'h700; size1 = 2'b00; sign1 = 1'b1;
        tick();
        chk("drop_ack0", ack_v[0], 2'b01);
        chk("drop_data0", rdata_v[0], 32'h0600F9FF);
        prev = cyc;
        wait_ack(0, 10, got, at);
        req_v[0] = 2'b00;
        chk("drop_next_port1", got, 2'b10);
        chk("drop_next_lat", at - prev, 3);
        tick();

        // Back-to-back reads against a three-cycle memory
        we = 2'b00; addr0 = 32'h300; size0 = 2'b10; sign0 = 1'b0;
        req_v[2] = 2'b01;
        prev = cyc;
        wait_ack(2, 12, got, at);
        chk("l3_first_lat", at - prev, 5);
        for (int k = 0; k < 2; k++) begin
            busy_cnt = 0;
            strobe_cnt = 0;
            for (int j = 0; j < 4; j++) begin
                tick();
                busy_cnt += int'(busy_v[2]);
                strobe_cnt += int'(rden_v[2]);
            end
            tick();
            if (k == 1) req_v[2] = 2'b00;
            chk($sformatf("l3_busy%0d", k), busy_cnt, 4);
            chk($sformatf("l3_strobes%0d", k), strobe_cnt, 1);
            chk($sformatf("l3_ack%0d", k), ack_v[2], 2'b01);
            chk($sformatf("l3_data%0d", k), rdata_v[2], 32'h0300FCFF);
        end
        tick();

        // Reset in the middle of a read abandons it
        we = 2'b00; addr0 = 32'h800; size0 = 2'b10;
        req_v[0] = 2'b01;
        tick();
        chk("rst_pre_strobe", rden_v[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_strobe_drop", rden_v[0], 1'b0);
        chk("rst_ack_low", ack_v[0], 2'b00);
        chk("rst_busy_low", busy_v[0], 1'b0);
        req_v[0] = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        late_acks = 0;
        repeat (6) begin
            tick();
            if (ack_v[0] != 2'b00) late_acks++;
        end
        chk("rst_no_late_ack", late_acks, 0);
        chk("rst_idle", busy_v[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
